// File: rtl/audio_tone_pkg.sv
// Shared types and constants for the square-wave audio tone generator:
// FSM states, control-word field positions and the note half-period table.
package audio_tone_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        OFFER     = 2'd2
    } tone_state_t;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_NOTE_LSB = 1;
    localparam int CTRL_NOTE_MSB = 3;
    localparam int CTRL_VOL_LSB  = 4;
    localparam int CTRL_VOL_MSB  = 7;

    // Half-periods in samples at 48 kHz, C4 up to C5.
    localparam logic [6:0] NOTE_HALF_PERIOD [0:7] = '{
        7'd92, 7'd82, 7'd73, 7'd69, 7'd61, 7'd55, 7'd49, 7'd46
    };

    function automatic logic [31:0] tone_level(input logic [3:0] volume,
                                               input logic       positive,
                                               input int         shift);
        logic [31:0] amp;
        amp = 32'(volume) << shift;
        return positive ? amp : -amp;
    endfunction

endpackage

// File: rtl/audio_tone_gen_if.sv
// Valid/ready sample stream from the tone generator to the audio FIFO.
interface audio_tone_gen_if;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/sample_tick_div.sv
// Free-running sample-rate divider: tick is high for one cycle every CLK_DIV
// cycles while clear is low; clear holds the count at zero.
module sample_tick_div #(
    parameter int CLK_DIV = 1042
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    assign tick = !clear && (tick_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator: emits one signed sample per divider tick on a
// valid/ready stream, switching notes only at half-period boundaries.
module audio_tone_gen
    import audio_tone_pkg::*;
#(
    parameter int CLK_DIV   = 1042,
    parameter int AMP_SHIFT = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ctrl,
    audio_tone_gen_if.master audio,
    output logic             overrun,
    output logic             busy
);
    tone_state_t state, state_next;

    logic [7:0]  ctrl_q;
    logic [2:0]  note_q;
    logic [6:0]  hp_cnt;
    logic        polarity;
    logic [31:0] sample_data;
    logic        sample_valid;

    logic tick, tick_clear, enable, handshake;
    logic start, load_sample, clear_valid, set_overrun;

    assign enable     = ctrl_q[CTRL_EN];
    assign handshake  = sample_valid && audio.sample_ready;
    assign busy       = (state != IDLE);
    assign tick_clear = (state == IDLE);

    assign audio.sample_data  = sample_data;
    assign audio.sample_valid = sample_valid;

    sample_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick arriving together with acceptance reloads the stream directly.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        load_sample = 1'b0;
        clear_valid = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT_TICK;
                    start      = 1'b1;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    load_sample = 1'b1;
                    state_next  = OFFER;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            OFFER: begin
                if (handshake) begin
                    if (tick) begin
                        load_sample = 1'b1;
                    end else begin
                        clear_valid = 1'b1;
                        state_next  = enable ? WAIT_TICK : IDLE;
                    end
                end else if (tick) begin
                    set_overrun = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q       <= '0;
            note_q       <= '0;
            hp_cnt       <= '0;
            polarity     <= 1'b1;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            ctrl_q <= ctrl;
            if (state == IDLE) begin
                hp_cnt   <= '0;
                polarity <= 1'b1;
            end
            if (start) begin
                note_q  <= ctrl_q[CTRL_NOTE_MSB:CTRL_NOTE_LSB];
                overrun <= 1'b0;
            end
            // Pitch advances on every tick, even when the sample is dropped.
            if (tick) begin
                if (hp_cnt == NOTE_HALF_PERIOD[note_q] - 7'd1) begin
                    hp_cnt   <= '0;
                    polarity <= ~polarity;
                    note_q   <= ctrl_q[CTRL_NOTE_MSB:CTRL_NOTE_LSB];
                end else begin
                    hp_cnt <= hp_cnt + 7'd1;
                end
            end
            if (load_sample) begin
                sample_data  <= tone_level(ctrl_q[CTRL_VOL_MSB:CTRL_VOL_LSB], polarity, AMP_SHIFT);
                sample_valid <= 1'b1;
            end else if (clear_valid) begin
                sample_valid <= 1'b0;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench for audio_tone_gen with a per-cycle reference model of the
// tone stream and hand-computed checks on latency, levels and note timing.
module tb_audio_tone_gen;
    localparam int CLK_DIV   = 4;
    localparam int AMP_SHIFT = 23;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ctrl = 8'h00;
    logic       overrun;
    logic       busy;

    audio_tone_gen_if aif();

    audio_tone_gen #(.CLK_DIV(CLK_DIV), .AMP_SHIFT(AMP_SHIFT)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl    (ctrl),
        .audio   (aif.master),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] samples[$];
    int          sample_cyc[$];

    int hp_table [8] = '{92, 82, 73, 69, 61, 55, 49, 46};

    logic [7:0]  m_ctrl_q;
    logic [31:0] m_data;
    bit          m_running, m_pending, m_overrun, m_started;
    bit          m_tick, m_acc;
    int          m_cyc, m_pos, m_halves, m_note, m_amp;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic rdy, input logic rst);
        ctrl = c;
        aif.sample_ready = rdy;
        reset = rst;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (aif.sample_valid !== 1'b1 && n < limit) begin
            step(1);
            n++;
        end
        checkOutput("valid_wait", {31'd0, aif.sample_valid}, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            step(1);
            n++;
        end
        checkOutput("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_samples(input int count, input int limit);
        int n = 0;
        while (samples.size() < count && n < limit) begin
            step(1);
            n++;
        end
        checkOutput("sample_wait", 32'(samples.size() >= count), 32'd1);
    endtask

    always @(posedge clk) cyc++;

    // Reference: tick every CLK_DIV cycles of activity, level sign flips after
    // each half-period of samples, new note only adopted at a flip.
    always @(posedge clk) begin
        if (reset) begin
            m_ctrl_q = 8'h00; m_running = 0; m_pending = 0; m_data = 0;
            m_overrun = 0; m_cyc = 0; m_pos = 0; m_halves = 0; m_note = 0;
        end else begin
            m_tick = m_running && (m_cyc % CLK_DIV == CLK_DIV - 1);
            m_acc  = m_pending && (aif.sample_ready == 1'b1);
            if (!m_running) begin
                if (m_ctrl_q[0]) begin
                    m_running = 1; m_cyc = 0; m_note = int'(m_ctrl_q[3:1]);
                    m_overrun = 0; m_pos = 0; m_halves = 0;
                end
            end else begin
                m_cyc++;
                if (m_tick) begin
                    m_amp = int'(m_ctrl_q[7:4]) * (1 << AMP_SHIFT);
                    if (m_pending && !m_acc) begin
                        m_overrun = 1;
                    end else begin
                        m_pending = 1;
                        m_data = (m_halves % 2 == 0) ? m_amp : -m_amp;
                    end
                    m_pos++;
                    if (m_pos == hp_table[m_note]) begin
                        m_pos = 0;
                        m_halves++;
                        m_note = int'(m_ctrl_q[3:1]);
                    end
                end else if (m_acc) begin
                    m_pending = 0;
                    if (!m_ctrl_q[0]) m_running = 0;
                end else if (!m_pending && !m_ctrl_q[0]) begin
                    m_running = 0;
                end
            end
            m_ctrl_q = ctrl;
        end
        m_started = 1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            checkOutput("model_valid", {31'd0, aif.sample_valid}, {31'd0, m_pending});
            checkOutput("model_busy", {31'd0, busy}, {31'd0, m_running});
            checkOutput("model_overrun", {31'd0, overrun}, {31'd0, m_overrun});
            if (m_pending) checkOutput("model_data", aif.sample_data, m_data);
        end
    end

    always @(negedge clk) begin
        if (!reset && aif.sample_valid === 1'b1 && aif.sample_ready === 1'b1) begin
            samples.push_back(aif.sample_data);
            sample_cyc.push_back(cyc);
        end
    end

    initial begin
        int n;
        int runs[$];
        int len;

        aif.sample_ready = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b1);
        step(2);
        checkOutput("reset_valid", {31'd0, aif.sample_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset_data", aif.sample_data, 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(1);

        $display("[TB] volume 1, note 5, ready high");
        applyStimulus(8'h1B, 1'b1, 1'b0);
        step(1);
        wait_valid(50, n);
        checkOutput("first_latency", 32'(n), 32'd5);
        checkOutput("first_data", aif.sample_data, 32'h0080_0000);
        wait_samples(56, 400);
        checkOutput("sample1", samples[0], 32'h0080_0000);
        checkOutput("sample55", samples[54], 32'h0080_0000);
        checkOutput("sample56", samples[55], 32'hFF80_0000);
        checkOutput("no_overrun", {31'd0, overrun}, 32'd0);

        $display("[TB] note change mid half-period");
        applyStimulus(8'h1A, 1'b1, 1'b0);
        wait_idle(50);
        samples.delete();
        applyStimulus(8'h1B, 1'b1, 1'b0);
        wait_samples(20, 200);
        applyStimulus(8'h1F, 1'b1, 1'b0);
        wait_samples(150, 800);
        len = 1;
        for (int i = 1; i < samples.size(); i++) begin
            if (samples[i] == samples[i-1]) len++;
            else begin
                runs.push_back(len);
                len = 1;
            end
        end
        while (runs.size() < 3) runs.push_back(0);
        checkOutput("run0_level", samples[0], 32'h0080_0000);
        checkOutput("run0_len", 32'(runs[0]), 32'd55);
        checkOutput("run1_len", 32'(runs[1]), 32'd46);
        checkOutput("run2_len", 32'(runs[2]), 32'd46);

        $display("[TB] volume 0");
        applyStimulus(8'h1E, 1'b1, 1'b0);
        wait_idle(50);
        samples.delete();
        sample_cyc.delete();
        applyStimulus(8'h0B, 1'b1, 1'b0);
        wait_samples(8, 100);
        for (int i = 0; i < 8; i++) begin
            checkOutput("zero_level", samples[i], 32'd0);
            if (i > 0) checkOutput("zero_spacing", 32'(sample_cyc[i] - sample_cyc[i-1]), 32'd4);
        end

        $display("[TB] full volume with stalled sink");
        applyStimulus(8'h0A, 1'b1, 1'b0);
        wait_idle(50);
        applyStimulus(8'hF1, 1'b0, 1'b0);
        wait_valid(50, n);
        checkOutput("stall_data0", aif.sample_data, 32'h0780_0000);
        for (int i = 0; i < 12; i++) begin
            step(1);
            checkOutput("stall_valid", {31'd0, aif.sample_valid}, 32'd1);
            checkOutput("stall_data", aif.sample_data, 32'h0780_0000);
        end
        checkOutput("stall_overrun", {31'd0, overrun}, 32'd1);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);

        $display("[TB] disable while offering");
        applyStimulus(8'h1A, 1'b0, 1'b0);
        step(2);
        checkOutput("disable_hold", {31'd0, aif.sample_valid}, 32'd1);
        applyStimulus(8'h1A, 1'b1, 1'b0);
        step(1);
        applyStimulus(8'h1A, 1'b0, 1'b0);
        checkOutput("disable_valid", {31'd0, aif.sample_valid}, 32'd0);
        checkOutput("disable_busy", {31'd0, busy}, 32'd0);

        $display("[TB] reset while offering");
        applyStimulus(8'h1B, 1'b0, 1'b0);
        wait_valid(50, n);
        step(1);
        applyStimulus(8'h1B, 1'b0, 1'b1);
        step(1);
        applyStimulus(8'h1B, 1'b0, 1'b0);
        checkOutput("rst_valid", {31'd0, aif.sample_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_data", aif.sample_data, 32'd0);
        step(1);
        wait_valid(50, n);
        checkOutput("rst_latency", 32'(n), 32'd5);
        checkOutput("rst_first_data", aif.sample_data, 32'h0080_0000);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_tone_gen.md
AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

Interface
REQ-001 Parameter CLK_DIV, default 1042, meaning clk cycles per audio sample (50 MHz / 48 kHz).
REQ-002 Parameter AMP_SHIFT, default 23, meaning left shift applied to the 4-bit volume to form the amplitude.
REQ-003 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port ctrl  in  8  control word from the audio control PIO: [0] enable, [3:1] note index, [7:4] volume.
REQ-006 Port sample_ready  in  1  downstream audio FIFO accepts a sample.
REQ-007 Port sample_data  out  32  signed two's-complement sample, written to both left and right channels downstream.
REQ-008 Port sample_valid  out  1  sample_data is offered.
REQ-009 Port overrun  out  1  sticky flag: a sample tick fell while a sample was still unaccepted.
REQ-010 Port busy  out  1  high in any state other than IDLE.

Function
REQ-011 ctrl SHALL be registered into ctrl_q every cycle; all decisions SHALL use ctrl_q only.
REQ-012 FSM states SHALL be IDLE, WAIT_TICK and OFFER.
REQ-013 IDLE: sample_valid=0, tick_cnt=0, hp_cnt=0, polarity=1; move to WAIT_TICK when ctrl_q[0]=1, load note_q from ctrl_q[3:1] and clear overrun.
REQ-014 WAIT_TICK: tick_cnt increments each cycle; at tick_cnt==CLK_DIV-1, tick_cnt becomes 0, the sample is computed, sample_valid is set, and the FSM moves to OFFER.
REQ-015 WAIT_TICK with ctrl_q[0]=0 and no tick SHALL return to IDLE.
REQ-016 The sample SHALL be +(volume<<AMP_SHIFT) when polarity=1, else its two's-complement negation; volume 0 SHALL give 0.
REQ-017 Volume SHALL be read from ctrl_q at each sample computation, so changes take effect on the next sample.
REQ-018 On each tick, hp_cnt SHALL advance; at hp_cnt==NOTE_HALF_PERIOD[note_q]-1, polarity toggles, hp_cnt becomes 0 and note_q reloads from ctrl_q[3:1]. A note change is therefore glitch-free, at a half-period boundary.
REQ-019 The sample value SHALL be formed from polarity before that tick's toggle.
REQ-020 OFFER: sample_data and sample_valid SHALL be held stable until sample_valid&&sample_ready. On that handshake, sample_valid falls the next cycle; the FSM goes to WAIT_TICK, or to IDLE if ctrl_q[0]=0.
REQ-021 tick_cnt SHALL keep counting in OFFER.
REQ-022 A tick in OFFER SHALL set overrun, advance hp_cnt/polarity per REQ-018, and leave the offered sample unchanged. That sample is dropped; pitch is preserved.
REQ-023 A handshake and a tick in the same OFFER cycle SHALL count as acceptance then tick: no overrun, and the next sample is loaded with sample_valid held high.
REQ-024 Deasserting enable SHALL never withdraw an offered sample.
REQ-025 Latency: with enable sampled into ctrl_q at edge E0, sample_valid SHALL first be high after edge E0+CLK_DIV+1.

Reset
REQ-026 While reset=1 at a clock edge, the FSM SHALL go to IDLE and sample_data=0, sample_valid=0, overrun=0, busy=0, ctrl_q=0, tick_cnt=0, hp_cnt=0, polarity=1, note_q=0.
REQ-027 Reset mid-OFFER SHALL drop the pending sample without a handshake; reset SHALL take priority over all other events.

Structure
REQ-028 Package audio_tone_pkg SHALL hold the FSM state enum, ctrl field positions, and NOTE_HALF_PERIOD[0:7] = 92, 82, 73, 69, 61, 55, 49, 46 (C4..C5 at 48 kHz).
REQ-029 The tick counter SHALL be the sub-module sample_tick_div (CLK_DIV parameter, clear input, tick output). All else is in audio_tone_gen.

Verification (CLK_DIV=4, AMP_SHIFT=23)
REQ-030 ctrl=0x1B, sample_ready=1: the first sample_data is 0x0080_0000, five cycles after ctrl_q samples enable; samples 1-55 are 0x0080_0000, sample 56 is 0xFF80_0000, and overrun stays 0.
REQ-031 ctrl=0xF1, sample_ready held 0 for 12 cycles: sample_valid stays high with 0x0780_0000 stable, overrun=1 after the first missed tick, busy=1.
REQ-032 Playing with ctrl=0x1B, change to 0x1F mid half-period: the current half-period completes at 55 samples, then subsequent half-periods are 46 samples.
REQ-033 ctrl=0x1A (enable low) while OFFER with sample_ready=0: sample_valid holds; raise sample_ready for 1 cycle -> handshake, then IDLE, sample_valid=0, busy=0.
REQ-034 Assert reset for 1 cycle mid-OFFER: the next cycle shows all outputs at REQ-026 values; re-enable gives the first sample after CLK_DIV+1 edges with polarity +.
REQ-035 Volume 0 (ctrl=0x0B): samples are 0x0000_0000 with valid handshakes continuing at one per 4 cycles.
